// File: rtl/bram_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bram_stream_reader : sequential BRAM reader, credit-managed FIFO,    |
// | valid/ready/last word stream.                        Revision 1.0    |
// +----------------------------------------------------------------------+
module bram_stream_reader #(
  parameter int ADDR_W     = 22,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 24,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              bram_0_clk,
  input  logic              bram_0_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_bytes,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] bram_0_addr,
  output logic              bram_0_en,
  output logic              bram_0_wr_en,
  input  logic [DATA_W-1:0] bram_0_rddata,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OUT_W  = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  n_start;
  logic              en_q, en_d;
  logic              tag_q, tag_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [RD_LAT-1:0] pipe_vld_q;
  logic [RD_LAT-1:0] pipe_last_q;

  logic [DATA_W-1:0]     mem_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_last;
  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  logic [FCNT_W-1:0]     count_q, count_d, count_left;

  logic              mv_q, mv_d;
  logic              ml_q, ml_d;
  logic [DATA_W-1:0] md_q, md_d;

  logic              pop;
  logic              wr;
  logic              can_issue;
  logic [OUT_W-1:0]  outstanding;

  // Word count rounds a trailing partial word up to a whole word.
  assign n_start = CNT_W'(({1'b0, num_bytes} + (CNT_W + 1)'(3)) >> 2);

  assign pop = mv_q & m_ready;
  assign wr  = pipe_vld_q[RD_LAT-1];

  // Words already committed to the FIFO: stored, on the BRAM port, or in the
  // read pipeline, less the one leaving this cycle.
  always_comb begin
    outstanding = OUT_W'(count_q) + OUT_W'(en_q);
    for (int i = 0; i < RD_LAT; i++) begin
      outstanding = outstanding + OUT_W'(pipe_vld_q[i]);
    end
    outstanding = outstanding - OUT_W'(pop);
  end

  assign can_issue = (issued_q < n_q) && (outstanding < OUT_W'(FIFO_DEPTH));

  always_ff @(posedge bram_0_clk) begin
    if (bram_0_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (n_start == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (issued_q == n_q) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && ml_q) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered read-port and status outputs.
  always_comb begin
    n_d      = n_q;
    issued_d = issued_q;
    en_d     = 1'b0;
    addr_d   = addr_q;
    tag_d    = 1'b0;
    busy_d   = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d   = (state_d == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (start && (n_start != '0)) begin
          n_d      = n_start;
          issued_d = CNT_W'(1);
          en_d     = 1'b1;
          addr_d   = base_addr;
          tag_d    = (n_start == CNT_W'(1));
        end
      end
      S_RUN: begin
        if (can_issue) begin
          issued_d = issued_q + CNT_W'(1);
          en_d     = 1'b1;
          addr_d   = addr_q + ADDR_W'(1);
          tag_d    = (issued_q == (n_q - CNT_W'(1)));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge bram_0_clk) begin
    if (bram_0_rst) begin
      n_q         <= '0;
      issued_q    <= '0;
      en_q        <= 1'b0;
      tag_q       <= 1'b0;
      addr_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
    end else begin
      n_q            <= n_d;
      issued_q       <= issued_d;
      en_q           <= en_d;
      tag_q          <= tag_d;
      addr_q         <= addr_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      pipe_vld_q[0]  <= en_q;
      pipe_last_q[0] <= tag_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_last_q[i] <= pipe_last_q[i-1];
      end
    end
  end

  // FIFO bookkeeping; the head is copied into output registers so the
  // stream outputs come straight from flops.
  always_comb begin
    count_left = count_q - FCNT_W'(pop);
    rptr_d     = rptr_q;
    if (pop) begin
      rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_W'(1);
    end
    wptr_d = wptr_q;
    if (wr) begin
      wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_W'(1);
    end
    count_d = count_left + FCNT_W'(wr);
    mv_d    = (count_d != '0);
    md_d    = md_q;
    ml_d    = 1'b0;
    if (count_left != '0) begin
      md_d = mem_data[rptr_d];
      ml_d = mem_last[rptr_d];
    end else if (wr) begin
      md_d = bram_0_rddata;
      ml_d = pipe_last_q[RD_LAT-1];
    end
  end

  always_ff @(posedge bram_0_clk) begin
    if (wr && !bram_0_rst) begin
      mem_data[wptr_q] <= bram_0_rddata;
      mem_last[wptr_q] <= pipe_last_q[RD_LAT-1];
    end
  end

  always_ff @(posedge bram_0_clk) begin
    if (bram_0_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      mv_q    <= 1'b0;
      ml_q    <= 1'b0;
      md_q    <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      mv_q    <= mv_d;
      ml_q    <= ml_d;
      md_q    <= md_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign bram_0_addr  = addr_q;
  assign bram_0_en    = en_q;
  assign bram_0_wr_en = 1'b0;
  assign m_data       = md_q;
  assign m_valid      = mv_q;
  assign m_last       = ml_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bram_stream_reader : directed vector bench for bram_stream_reader |
// | with a 1-cycle-latency BRAM model.                   Revision 1.0    |
// +----------------------------------------------------------------------+
module tb_bram_stream_reader;

  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [21:0] base_addr;
  logic [23:0] num_bytes;
  logic        busy, done;
  logic [21:0] bram_0_addr;
  logic        bram_0_en, bram_0_wr_en;
  logic [31:0] bram_0_rddata;
  logic [31:0] m_data;
  logic        m_valid, m_ready, m_last;

  bram_stream_reader #(
    .ADDR_W(22), .DATA_W(32), .CNT_W(24), .RD_LAT(1), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .bram_0_clk   (clk),
    .bram_0_rst   (rst),
    .start        (start),
    .base_addr    (base_addr),
    .num_bytes    (num_bytes),
    .busy         (busy),
    .done         (done),
    .bram_0_addr  (bram_0_addr),
    .bram_0_en    (bram_0_en),
    .bram_0_wr_en (bram_0_wr_en),
    .bram_0_rddata(bram_0_rddata),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last)
  );

  always #5 clk = ~clk;

  // SRAM contents: the four preloaded words, otherwise an address-derived tag.
  function automatic logic [31:0] mem_word(input logic [21:0] a);
    case (a)
      22'h100: mem_word = 32'h03020100;
      22'h101: mem_word = 32'h07060504;
      22'h102: mem_word = 32'h0B0A0908;
      22'h103: mem_word = 32'h0F0E0D0C;
      default: mem_word = 32'hC000_0000 | {10'd0, a};
    endcase
  endfunction

  always @(posedge clk) begin
    if (bram_0_en) bram_0_rddata <= mem_word(bram_0_addr);
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor state, sampled on the falling edge.
  bit          mon_on = 1'b0;
  int          t_start;
  logic [31:0] beat_d[$];
  logic        beat_l[$];
  logic [21:0] addr_log[$];
  int first_v, done_c, last_hs, issued_n, hs_n, busy_n, stall_err, outst_err;
  int wr_en_err = 0;
  bit          stall_prev, busy_at_done;
  logic [31:0] prev_d;
  logic        prev_l;

  always @(negedge clk) begin
    if (bram_0_wr_en !== 1'b0) wr_en_err++;
    if (mon_on) begin
      if (m_valid === 1'b1 && first_v < 0) first_v = cyc - t_start;
      if (bram_0_en === 1'b1) begin
        addr_log.push_back(bram_0_addr);
        issued_n++;
      end
      if (m_valid === 1'b1 && m_ready) begin
        beat_d.push_back(m_data);
        beat_l.push_back(m_last);
        hs_n++;
        last_hs = cyc - t_start;
      end
      if (issued_n - hs_n > FIFO_DEPTH) outst_err++;
      if (stall_prev && !(m_valid === 1'b1 && m_data === prev_d && m_last === prev_l))
        stall_err++;
      stall_prev = (m_valid === 1'b1) && !m_ready;
      prev_d = m_data;
      prev_l = m_last;
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1 && done_c < 0) begin
        done_c       = cyc - t_start;
        busy_at_done = busy;
      end
    end
  end

  typedef struct {
    logic [21:0] base;
    logic [23:0] nb;
    bit          toggle;    // m_ready pattern 1,0,0,1 instead of constant 1
    bit          glitch;    // second start with another base two cycles in
    int          words;
    int          first;     // first m_valid cycle after start, -1 for none
    int          done_lat;  // done cycle after start, -1 when stall-dependent
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  task automatic run_vec(input vec_t v, input int idx);
    int k;
    logic [21:0] ea;
    @(posedge clk); #1;
    beat_d.delete(); beat_l.delete(); addr_log.delete();
    first_v = -1; done_c = -1; last_hs = -1; issued_n = 0; hs_n = 0;
    busy_n = 0; stall_err = 0; outst_err = 0; stall_prev = 1'b0; busy_at_done = 1'b0;
    m_ready   = 1'b1;
    start     = 1'b1;
    base_addr = v.base;
    num_bytes = v.nb;
    t_start   = cyc;
    mon_on    = 1'b1;
    k = 0;
    while (done_c < 0 && k < 300) begin
      @(posedge clk); #1;
      k++;
      start = v.glitch && (k == 2);
      if (start) begin
        base_addr = 22'h300;
        num_bytes = 24'd8;
      end
      m_ready = v.toggle ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
    end
    start = 1'b0;
    @(posedge clk); #1;
    mon_on = 1'b0;
    chk($sformatf("v%0d_done_seen", idx), done_c > 0, 1'b1);
    if (v.done_lat >= 0) chk($sformatf("v%0d_done_lat", idx), done_c, v.done_lat);
    chk($sformatf("v%0d_busy_at_done", idx), busy_at_done, 1'b0);
    chk($sformatf("v%0d_busy_cycles", idx), busy_n, done_c - 1);
    chk($sformatf("v%0d_first_valid", idx), first_v, v.first);
    chk($sformatf("v%0d_beats", idx), beat_d.size(), v.words);
    chk($sformatf("v%0d_reads", idx), addr_log.size(), v.words);
    for (int i = 0; i < v.words; i++) begin
      ea = v.base + 22'(i);
      chk($sformatf("v%0d_addr%0d", idx, i), (i < addr_log.size()) ? addr_log[i] : 22'hx, ea);
      chk($sformatf("v%0d_data%0d", idx, i), (i < beat_d.size()) ? beat_d[i] : 32'hx, mem_word(ea));
      chk($sformatf("v%0d_last%0d", idx, i), (i < beat_l.size()) ? beat_l[i] : 1'bx, i == v.words - 1);
    end
    if (v.words > 0) chk($sformatf("v%0d_last_hs", idx), last_hs, done_c - 1);
    chk($sformatf("v%0d_stall_hold", idx), stall_err, 0);
    chk($sformatf("v%0d_outstanding", idx), outst_err, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},   busy,         1'b0);
    chk({tag, "_done"},   done,         1'b0);
    chk({tag, "_en"},     bram_0_en,    1'b0);
    chk({tag, "_addr"},   bram_0_addr,  22'h0);
    chk({tag, "_wr_en"},  bram_0_wr_en, 1'b0);
    chk({tag, "_valid"},  m_valid,      1'b0);
    chk({tag, "_last"},   m_last,       1'b0);
    chk({tag, "_data"},   m_data,       32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{base:22'h100,    nb:24'd16, toggle:1'b0, glitch:1'b0, words:4,  first:3,  done_lat:7};
    vecs[1] = '{base:22'h100,    nb:24'd16, toggle:1'b1, glitch:1'b0, words:4,  first:3,  done_lat:-1};
    vecs[2] = '{base:22'h200,    nb:24'd0,  toggle:1'b0, glitch:1'b0, words:0,  first:-1, done_lat:1};
    vecs[3] = '{base:22'h3FFFFF, nb:24'd6,  toggle:1'b0, glitch:1'b0, words:2,  first:3,  done_lat:5};
    vecs[4] = '{base:22'h100,    nb:24'd16, toggle:1'b1, glitch:1'b1, words:4,  first:3,  done_lat:-1};
    vecs[5] = '{base:22'h20,     nb:24'd13, toggle:1'b0, glitch:1'b0, words:4,  first:3,  done_lat:7};
    vecs[6] = '{base:22'h40,     nb:24'd40, toggle:1'b0, glitch:1'b0, words:10, first:3,  done_lat:13};
    vecs[7] = '{base:22'h3FFFFE, nb:24'd9,  toggle:1'b1, glitch:1'b0, words:3,  first:3,  done_lat:-1};
    vecs[8] = '{base:22'h55,     nb:24'd4,  toggle:1'b0, glitch:1'b0, words:1,  first:3,  done_lat:4};

    rst = 1'b1; start = 1'b0; base_addr = '0; num_bytes = '0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < NV - 1; i++) run_vec(vecs[i], i);

    // Reset in the middle of a stalled transfer.
    @(posedge clk); #1;
    m_ready = 1'b0; start = 1'b1; base_addr = 22'h100; num_bytes = 24'd32;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    chk("prerst_valid", m_valid, 1'b1);
    chk("prerst_busy",  busy,    1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");

    run_vec(vecs[NV-1], NV - 1);

    chk("wr_en_zero", wr_en_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bram_stream_reader.md
# bram_stream_reader

Read-side master for the weight/bias/input SRAM port that the loader fills with 32-bit words via `bram_0_en`/`bram_0_wr_en`/`bram_0_addr`/`bram_0_wrdata`. Given a base word address and a byte count, it issues sequential BRAM reads, absorbs the BRAM read latency in a small FIFO, and presents the words on a valid/ready stream with a last flag. It sits between the SRAM and the systolic-array feeders, and lets a bench read back and check what the loader wrote.

## Interface
- `ADDR_W`, 22: BRAM word-address width.
- `DATA_W`, 32: word width; byte 0 of a word is in bits [7:0].
- `CNT_W`, 24: byte-count width.
- `RD_LAT`, 1: BRAM read latency in cycles (1 or 2).
- `FIFO_DEPTH`, 4: output FIFO entries; must be ≥ RD_LAT+2.

- `bram_0_clk`  in  1  sole clock, rising edge.
- `bram_0_rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `base_addr`  in  ADDR_W  first word address, sampled with `start`.
- `num_bytes`  in  CNT_W  transfer length in bytes, sampled with `start`.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse after the final word is accepted.
- `bram_0_addr`  out  ADDR_W  read word address.
- `bram_0_en`  out  1  read enable.
- `bram_0_wr_en`  out  1  constant 0.
- `bram_0_rddata`  in  DATA_W  read data, valid RD_LAT cycles after `bram_0_en`.
- `m_data`  out  DATA_W  stream word.
- `m_valid`  out  1  `m_data` valid.
- `m_ready`  in  1  consumer accepts when high with `m_valid`.
- `m_last`  out  1  marks the final word; qualified by `m_valid`.

## Operation
- Word count N = ceil(num_bytes/4), computed at `start`. A trailing partial word is read whole and not masked.
- States:
  - IDLE: `start` with N>0 latches `base_addr` and N, then goes to RUN. `start` with N=0 goes to DONE with no reads.
  - RUN: in each cycle where issued<N and (fifo_count + in_flight) < FIFO_DEPTH, assert `bram_0_en`, drive the current address, then increment the address and `issued`. When issued==N, go to DRAIN.
  - DRAIN: issues no reads. Leaves when the word with `m_last` is handshaked, going to DONE.
  - DONE: one cycle, `done`=1, then IDLE.
- A returning word is written into the FIFO exactly RD_LAT cycles after its `bram_0_en`. The credit rule above makes FIFO overflow impossible.
- `m_last` = 1 on the FIFO head entry that is word N-1. The FIFO carries a last tag per entry.
- Address arithmetic is modulo 2^ADDR_W: base 0x3FFFFF, N=2 reads 0x3FFFFF then 0x000000.
- `start` outside IDLE is ignored, with no effect on the current transfer.
- `m_valid`/`m_data`/`m_last` hold stable while `m_valid`=1 and `m_ready`=0.
- Reset at any time: return to IDLE, flush the FIFO, and discard in-flight reads. Data returning after reset is dropped.

## Timing
- Reset values: `busy`=0, `done`=0, `bram_0_en`=0, `bram_0_addr`=0, `bram_0_wr_en`=0, `m_valid`=0, `m_last`=0, `m_data`=0.
- `start` in cycle t (N>0):
  - first `bram_0_en` in t+1;
  - FIFO write at the end of t+1+RD_LAT;
  - first `m_valid` in t+2+RD_LAT (t+3 for RD_LAT=1).
- With `m_ready` held at 1, reads and outputs sustain 1 word/cycle. The last handshake occurs at t+1+RD_LAT+N.
- `busy` = 1 from t+1 through the cycle of the last handshake.
- `done` = 1 the following cycle, with `busy`=0. A `start` in the DONE cycle is ignored; the next start is accepted in the cycle after.
- N=0: `done` in t+1, `busy` never asserted.
- All outputs are registered.

## Test plan
- Reset, then preload SRAM words 0x100..0x103 = 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C. Pulse `start` with base 0x100, num_bytes=16, `m_ready`=1. Required: 4 consecutive beats in that order, `m_last` on beat 4, `done` one cycle after, first `m_valid` at t+3.
- Same transfer with `m_ready` toggling 1,0,0,1 repeating. Required: data is held stable under stall, there are never more than FIFO_DEPTH outstanding reads, and the order and data are unchanged.
- num_bytes=0. Required: `done` at t+1, no `bram_0_en`, no `m_valid`.
- num_bytes=6, base 0x3FFFFF. Required: 2 reads at 0x3FFFFF then 0x000000, 2 beats, `m_last` on the second.
- Assert `bram_0_rst` mid-RUN with `m_ready`=0. Required: next cycle all outputs equal their reset values. A subsequent 1-word transfer returns only its own word.
- `start` pulsed during RUN with a different base. Required: ignored, and the original transfer completes intact. `bram_0_wr_en` stays 0 in every scenario.
